// File: rtl/bure_pkg.sv
// BureCore shared types for the memory-access stage.
// Enumerations, the writeback bundle and the in-flight request context.
package bure_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      MEM_NONE  = 2'd0,
      MEM_LOAD  = 2'd1,
      MEM_STORE = 2'd2
   } mem_op_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } mem_size_e;

   typedef enum logic [1:0] {
      EXC_NONE         = 2'd0,
      EXC_LD_MISALIGN  = 2'd1,
      EXC_ST_MISALIGN  = 2'd2,
      EXC_ACCESS_FAULT = 2'd3
   } exc_cause_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } mem_state_e;

   typedef struct packed {
      logic [4:0]      rd;
      logic            we;
      logic [XLEN-1:0] data;
      logic            exc;
      exc_cause_e      cause;
   } wb_t;

   typedef struct packed {
      logic [1:0] off;
      mem_size_e  size;
      logic       uns;
      logic       store;
      logic [4:0] rd;
      logic       rd_we;
   } mem_ctx_t;

endpackage

// File: rtl/bure_lsu_align.sv
// Lane steering for the memory stage: store byte enables and
// replication, load shift and extension, misalignment detection.
module bure_lsu_align
   import bure_pkg::*;
(
   input  logic [1:0]      st_off,
   input  mem_size_e       st_size,
   input  logic [XLEN-1:0] st_data,
   output logic [3:0]      st_be,
   output logic [XLEN-1:0] st_wdata,
   output logic            misalign,
   input  logic [1:0]      ld_off,
   input  mem_size_e       ld_size,
   input  logic            ld_uns,
   input  logic [XLEN-1:0] ld_rdata,
   output logic [XLEN-1:0] ld_data
);

   logic [XLEN-1:0] shifted;

   always_comb begin
      st_be    = '0;
      st_wdata = '0;
      misalign = 1'b0;
      unique case (1'b1)
         (st_size == SZ_BYTE): begin
            st_be    = 4'b0001 << st_off;
            st_wdata = {4{st_data[7:0]}};
         end
         (st_size == SZ_HALF): begin
            st_be    = 4'b0011 << st_off;
            st_wdata = {2{st_data[15:0]}};
            misalign = st_off[0];
         end
         default: begin
            st_be    = 4'hF;
            st_wdata = st_data;
            misalign = |st_off;
         end
      endcase
   end

   assign shifted = ld_rdata >> {ld_off, 3'b000};

   always_comb begin
      ld_data = shifted;
      unique case (1'b1)
         (ld_size == SZ_BYTE):
            ld_data = {{24{~ld_uns & shifted[7]}}, shifted[7:0]};
         (ld_size == SZ_HALF):
            ld_data = {{16{~ld_uns & shifted[15]}}, shifted[15:0]};
         default:
            ld_data = shifted;
      endcase
   end

endmodule

// File: rtl/bure_stage_mem.sv
// BureCore memory-access stage: one instruction in flight,
// aligned dmem request/response and a registered writeback result.
module bure_stage_mem
   import bure_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_ex_valid,
   output logic                  o_ex_ready,
   input  logic [DATA_WIDTH-1:0] i_ex_result,
   input  logic [DATA_WIDTH-1:0] i_ex_store_data,
   input  logic [4:0]            i_ex_rd,
   input  logic                  i_ex_rd_we,
   input  logic [1:0]            i_ex_mem_op,
   input  logic [1:0]            i_ex_mem_size,
   input  logic                  i_ex_mem_uns,
   output logic                  o_dmem_req,
   input  logic                  i_dmem_gnt,
   output logic [ADDR_WIDTH-1:0] o_dmem_addr,
   output logic                  o_dmem_we,
   output logic [3:0]            o_dmem_be,
   output logic [DATA_WIDTH-1:0] o_dmem_wdata,
   input  logic                  i_dmem_rvalid,
   input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
   input  logic                  i_dmem_err,
   output logic                  o_wb_valid,
   input  logic                  i_wb_ready,
   output logic [4:0]            o_wb_rd,
   output logic                  o_wb_we,
   output logic [DATA_WIDTH-1:0] o_wb_data,
   output logic                  o_wb_exc,
   output logic [1:0]            o_wb_exc_cause
);

   if (DATA_WIDTH != 32) begin : g_dw_check
      $error("bure_stage_mem: only DATA_WIDTH=32 is supported");
   end

   mem_state_e      state_q, state_d;
   mem_op_e         ex_op;
   mem_size_e       ex_size;
   logic            accept;
   logic            is_mem;
   logic            misalign;
   logic            go_req;
   logic [3:0]      st_be;
   logic [XLEN-1:0] st_wdata;
   logic [XLEN-1:0] ld_data;
   mem_ctx_t        ctx_q;
   wb_t             wb_q, wb_d;
   logic            wb_load;
   logic            wb_valid_q;

   assign ex_op   = mem_op_e'(i_ex_mem_op);
   assign ex_size = mem_size_e'(i_ex_mem_size);
   assign accept  = i_ex_valid && o_ex_ready;
   assign is_mem  = (ex_op == MEM_LOAD) || (ex_op == MEM_STORE);
   assign go_req  = accept && is_mem && !misalign;

   bure_lsu_align u_align (
      .st_off   (i_ex_result[1:0]),
      .st_size  (ex_size),
      .st_data  (i_ex_store_data),
      .st_be    (st_be),
      .st_wdata (st_wdata),
      .misalign (misalign),
      .ld_off   (ctx_q.off),
      .ld_size  (ctx_q.size),
      .ld_uns   (ctx_q.uns),
      .ld_rdata (i_dmem_rdata),
      .ld_data  (ld_data)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (go_req)        state_d = REQ;
         REQ:     if (i_dmem_gnt)    state_d = RESP;
         RESP:    if (i_dmem_rvalid) state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   // Ready is gated by reset so nothing is accepted while it is held.
   always_comb begin
      o_ex_ready = 1'b0;
      o_dmem_req = 1'b0;
      unique case (state_q)
         IDLE:    o_ex_ready = !i_rst && (!wb_valid_q || i_wb_ready);
         REQ:     o_dmem_req = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      wb_load = 1'b0;
      wb_d    = wb_q;
      if (accept && !go_req) begin
         wb_load    = 1'b1;
         wb_d.rd    = i_ex_rd;
         wb_d.we    = i_ex_rd_we && !is_mem;
         wb_d.data  = is_mem ? '0 : i_ex_result;
         wb_d.exc   = is_mem;
         wb_d.cause = !is_mem ? EXC_NONE :
                      (ex_op == MEM_LOAD) ? EXC_LD_MISALIGN :
                      EXC_ST_MISALIGN;
      end else if (state_q == RESP && i_dmem_rvalid) begin
         wb_load    = 1'b1;
         wb_d.rd    = ctx_q.rd;
         wb_d.we    = ctx_q.rd_we && !ctx_q.store && !i_dmem_err;
         wb_d.data  = (ctx_q.store || i_dmem_err) ? '0 : ld_data;
         wb_d.exc   = i_dmem_err;
         wb_d.cause = i_dmem_err ? EXC_ACCESS_FAULT : EXC_NONE;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ctx_q        <= '0;
         o_dmem_addr  <= '0;
         o_dmem_we    <= 1'b0;
         o_dmem_be    <= '0;
         o_dmem_wdata <= '0;
      end else if (go_req) begin
         ctx_q.off    <= i_ex_result[1:0];
         ctx_q.size   <= ex_size;
         ctx_q.uns    <= i_ex_mem_uns;
         ctx_q.store  <= (ex_op == MEM_STORE);
         ctx_q.rd     <= i_ex_rd;
         ctx_q.rd_we  <= i_ex_rd_we;
         o_dmem_addr  <= {i_ex_result[ADDR_WIDTH-1:2], 2'b00};
         o_dmem_we    <= (ex_op == MEM_STORE);
         o_dmem_be    <= st_be;
         o_dmem_wdata <= (ex_op == MEM_STORE) ? st_wdata : '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wb_valid_q <= 1'b0;
         wb_q       <= '0;
      end else if (wb_load) begin
         wb_valid_q <= 1'b1;
         wb_q       <= wb_d;
      end else if (i_wb_ready) begin
         wb_valid_q <= 1'b0;
      end
   end

   assign o_wb_valid     = wb_valid_q;
   assign o_wb_rd        = wb_q.rd;
   assign o_wb_we        = wb_q.we;
   assign o_wb_data      = wb_q.data;
   assign o_wb_exc       = wb_q.exc;
   assign o_wb_exc_cause = wb_q.cause;

endmodule

// File: tb/tb_bure_stage_mem.sv
// Bench for bure_stage_mem: directed scenarios plus random traffic
// against a word-addressed memory model.
module tb_bure_stage_mem;

   localparam logic [1:0] OP_NONE = 2'd0;
   localparam logic [1:0] OP_LD   = 2'd1;
   localparam logic [1:0] OP_ST   = 2'd2;
   localparam logic [1:0] SZ_B    = 2'd0;
   localparam logic [1:0] SZ_H    = 2'd1;
   localparam logic [1:0] SZ_W    = 2'd2;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_ex_valid;
   logic        o_ex_ready;
   logic [31:0] i_ex_result;
   logic [31:0] i_ex_store_data;
   logic [4:0]  i_ex_rd;
   logic        i_ex_rd_we;
   logic [1:0]  i_ex_mem_op;
   logic [1:0]  i_ex_mem_size;
   logic        i_ex_mem_uns;
   logic        o_dmem_req;
   logic        i_dmem_gnt;
   logic [31:0] o_dmem_addr;
   logic        o_dmem_we;
   logic [3:0]  o_dmem_be;
   logic [31:0] o_dmem_wdata;
   logic        i_dmem_rvalid;
   logic [31:0] i_dmem_rdata;
   logic        i_dmem_err;
   logic        o_wb_valid;
   logic        i_wb_ready;
   logic [4:0]  o_wb_rd;
   logic        o_wb_we;
   logic [31:0] o_wb_data;
   logic        o_wb_exc;
   logic [1:0]  o_wb_exc_cause;

   int n_chk  = 0;
   int n_fail = 0;
   int unsigned mem [int unsigned];

   bure_stage_mem dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_ex_valid      (i_ex_valid),
      .o_ex_ready      (o_ex_ready),
      .i_ex_result     (i_ex_result),
      .i_ex_store_data (i_ex_store_data),
      .i_ex_rd         (i_ex_rd),
      .i_ex_rd_we      (i_ex_rd_we),
      .i_ex_mem_op     (i_ex_mem_op),
      .i_ex_mem_size   (i_ex_mem_size),
      .i_ex_mem_uns    (i_ex_mem_uns),
      .o_dmem_req      (o_dmem_req),
      .i_dmem_gnt      (i_dmem_gnt),
      .o_dmem_addr     (o_dmem_addr),
      .o_dmem_we       (o_dmem_we),
      .o_dmem_be       (o_dmem_be),
      .o_dmem_wdata    (o_dmem_wdata),
      .i_dmem_rvalid   (i_dmem_rvalid),
      .i_dmem_rdata    (i_dmem_rdata),
      .i_dmem_err      (i_dmem_err),
      .o_wb_valid      (o_wb_valid),
      .i_wb_ready      (i_wb_ready),
      .o_wb_rd         (o_wb_rd),
      .o_wb_we         (o_wb_we),
      .o_wb_data       (o_wb_data),
      .o_wb_exc        (o_wb_exc),
      .o_wb_exc_cause  (o_wb_exc_cause)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (!mem.exists(a)) mem[a] = $urandom;
      return mem[a];
   endfunction

   // Drives one instruction and checks request and result against the model.
   task automatic do_op(input string nm, input logic [1:0] op,
                        input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [4:0] rd, input logic rdwe,
                        input int gd, input int rdl, input logic err,
                        input int hold);
      int nb, off, w, bm;
      logic mis, ismem, dknown;
      logic [31:0] exp_addr, exp_wdata, word, exp_data, mask;
      logic [3:0] exp_be;
      logic exp_we, exp_exc;
      logic [1:0] exp_cause;
      logic [63:0] v;
      nb = (sz == SZ_B) ? 1 : (sz == SZ_H) ? 2 : 4;
      off = int'(addr % 4);
      ismem = (op == OP_LD) || (op == OP_ST);
      mis = ismem && (addr % nb != 0);
      w = 0;
      while (!o_ex_ready && w < 20) begin
         tick;
         w++;
      end
      n_chk++;
      if (o_ex_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s ready: got %b want 1", nm, o_ex_ready);
      end
      i_ex_valid = 1'b1;
      i_ex_result = addr;
      i_ex_store_data = sd;
      i_ex_rd = rd;
      i_ex_rd_we = rdwe;
      i_ex_mem_op = op;
      i_ex_mem_size = sz;
      i_ex_mem_uns = uns;
      tick;
      i_ex_valid = 1'b0;
      exp_data = 32'h0;
      dknown = 1'b1;
      if (!ismem || mis) begin
         exp_we = mis ? 1'b0 : rdwe;
         exp_exc = mis;
         exp_cause = !mis ? 2'd0 : (op == OP_LD) ? 2'd1 : 2'd2;
         exp_data = addr;
         dknown = !mis;
         n_chk++;
         if ({o_wb_valid, o_dmem_req, o_wb_rd, o_wb_we, o_wb_exc,
              o_wb_exc_cause} !==
             {1'b1, 1'b0, rd, exp_we, exp_exc, exp_cause}) begin
            n_fail++;
            $display("FAIL %s lat1: got v=%b req=%b rd=%0d we=%b exc=%b c=%0d want v=1 req=0 rd=%0d we=%b exc=%b c=%0d",
                     nm, o_wb_valid, o_dmem_req, o_wb_rd, o_wb_we,
                     o_wb_exc, o_wb_exc_cause, rd, exp_we, exp_exc,
                     exp_cause);
         end
         if (dknown) begin
            n_chk++;
            if (o_wb_data !== exp_data) begin
               n_fail++;
               $display("FAIL %s data: got %h want %h", nm,
                        o_wb_data, exp_data);
            end
         end
      end else begin
         exp_addr = addr - 32'(off);
         bm = ((1 << nb) - 1) << off;
         exp_be = bm[3:0];
         exp_we = (op == OP_ST);
         exp_wdata = (nb == 1) ? (sd & 32'hFF) * 32'h0101_0101 :
                     (nb == 2) ? (sd & 32'hFFFF) * 32'h0001_0001 : sd;
         for (int c = 0; c <= gd; c++) begin
            n_chk++;
            if ({o_dmem_req, o_dmem_addr, o_dmem_we, o_dmem_be} !==
                {1'b1, exp_addr, exp_we, exp_be}) begin
               n_fail++;
               $display("FAIL %s req c%0d: got r=%b a=%h we=%b be=%b want r=1 a=%h we=%b be=%b",
                        nm, c, o_dmem_req, o_dmem_addr, o_dmem_we,
                        o_dmem_be, exp_addr, exp_we, exp_be);
            end
            if (exp_we) begin
               n_chk++;
               if (o_dmem_wdata !== exp_wdata) begin
                  n_fail++;
                  $display("FAIL %s wdata: got %h want %h", nm,
                           o_dmem_wdata, exp_wdata);
               end
            end
            if (c < gd) tick;
         end
         i_dmem_gnt = 1'b1;
         tick;
         i_dmem_gnt = 1'b0;
         n_chk++;
         if ({o_dmem_req, o_wb_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s after gnt: got req=%b v=%b want 0 0",
                     nm, o_dmem_req, o_wb_valid);
         end
         repeat (rdl) tick;
         word = mem_word(exp_addr);
         i_dmem_rvalid = 1'b1;
         i_dmem_rdata = (op == OP_LD) ? word : $urandom;
         i_dmem_err = err;
         tick;
         i_dmem_rvalid = 1'b0;
         i_dmem_err = 1'b0;
         if (err) begin
            exp_we = 1'b0;
            exp_exc = 1'b1;
            exp_cause = 2'd3;
         end else if (op == OP_ST) begin
            exp_we = 1'b0;
            exp_exc = 1'b0;
            exp_cause = 2'd0;
            mask = 32'h0;
            for (int b = 0; b < 4; b++)
               if (exp_be[b]) mask[8*b +: 8] = 8'hFF;
            mem[exp_addr] = (word & ~mask) | (exp_wdata & mask);
         end else begin
            exp_we = rdwe;
            exp_exc = 1'b0;
            exp_cause = 2'd0;
            v = {32'h0, word} >> (8 * off);
            v = v & ((64'd1 << (8 * nb)) - 64'd1);
            if (!uns && nb < 4 && v >= (64'd1 << (8 * nb - 1)))
               v = v + 64'h1_0000_0000 - (64'd1 << (8 * nb));
            exp_data = v[31:0];
         end
         n_chk++;
         if ({o_wb_valid, o_wb_rd, o_wb_we, o_wb_data, o_wb_exc,
              o_wb_exc_cause} !==
             {1'b1, rd, exp_we, exp_data, exp_exc, exp_cause}) begin
            n_fail++;
            $display("FAIL %s resp: got v=%b rd=%0d we=%b d=%h exc=%b c=%0d want v=1 rd=%0d we=%b d=%h exc=%b c=%0d",
                     nm, o_wb_valid, o_wb_rd, o_wb_we, o_wb_data,
                     o_wb_exc, o_wb_exc_cause, rd, exp_we, exp_data,
                     exp_exc, exp_cause);
         end
      end
      if (hold > 0) begin
         i_wb_ready = 1'b0;
         repeat (hold) begin
            tick;
            n_chk++;
            if ({o_wb_valid, o_ex_ready, o_wb_rd, o_wb_we, o_wb_exc,
                 o_wb_exc_cause} !==
                {1'b1, 1'b0, rd, exp_we, exp_exc, exp_cause} ||
                (dknown && o_wb_data !== exp_data)) begin
               n_fail++;
               $display("FAIL %s hold: got v=%b rdy=%b d=%h exc=%b want v=1 rdy=0 d=%h exc=%b",
                        nm, o_wb_valid, o_ex_ready, o_wb_data, o_wb_exc,
                        exp_data, exp_exc);
            end
         end
         i_wb_ready = 1'b1;
         tick;
         n_chk++;
         if (o_wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s drain: got v=%b want 0", nm, o_wb_valid);
         end
      end
   endtask

   task automatic test_reset;
      i_rst = 1'b1;
      repeat (3) tick;
      n_chk++;
      if ({o_ex_ready, o_dmem_req, o_wb_valid, o_wb_exc} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset ctl: got rdy=%b req=%b v=%b exc=%b want 0",
                  o_ex_ready, o_dmem_req, o_wb_valid, o_wb_exc);
      end
      n_chk++;
      if ({o_dmem_addr, o_dmem_we, o_dmem_be, o_dmem_wdata, o_wb_rd,
           o_wb_we, o_wb_data, o_wb_exc_cause} !== '0) begin
         n_fail++;
         $display("FAIL reset data: got a=%h be=%b wd=%h rd=%0d d=%h want 0",
                  o_dmem_addr, o_dmem_be, o_dmem_wdata, o_wb_rd, o_wb_data);
      end
      i_rst = 1'b0;
      #1;
      n_chk++;
      if (o_ex_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset release: got rdy=%b want 1", o_ex_ready);
      end
   endtask

   task automatic test_alu;
      do_op("alu", OP_NONE, SZ_W, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b1,
            0, 0, 1'b0, 0);
      do_op("alu_x0", OP_NONE, SZ_W, 1'b0, 32'hCAFE_0001, 32'h0, 5'd0,
            1'b1, 0, 0, 1'b0, 0);
   endtask

   task automatic test_load_byte;
      mem[32'h100] = 32'h80FF_FF00;
      do_op("lb", OP_LD, SZ_B, 1'b0, 32'h103, 32'h0, 5'd7, 1'b1,
            0, 0, 1'b0, 0);
      do_op("lbu", OP_LD, SZ_B, 1'b1, 32'h103, 32'h0, 5'd8, 1'b1,
            0, 0, 1'b0, 0);
      do_op("lh_x0", OP_LD, SZ_H, 1'b0, 32'h102, 32'h0, 5'd0, 1'b1,
            0, 1, 1'b0, 0);
   endtask

   task automatic test_store_half;
      do_op("sh", OP_ST, SZ_H, 1'b0, 32'h202, 32'hAAAA_BEEF, 5'd9, 1'b1,
            3, 0, 1'b0, 0);
      do_op("lw_after_sh", OP_LD, SZ_W, 1'b0, 32'h200, 32'h0, 5'd10,
            1'b1, 0, 0, 1'b0, 0);
   endtask

   task automatic test_misalign;
      do_op("lw_mis", OP_LD, SZ_W, 1'b0, 32'h101, 32'h0, 5'd3, 1'b1,
            0, 0, 1'b0, 0);
      do_op("sw_mis", OP_ST, SZ_W, 1'b0, 32'h102, 32'h1, 5'd3, 1'b0,
            0, 0, 1'b0, 0);
      do_op("lh_mis", OP_LD, SZ_H, 1'b1, 32'h103, 32'h0, 5'd4, 1'b1,
            0, 0, 1'b0, 2);
   endtask

   task automatic test_access_fault;
      do_op("lw_err", OP_LD, SZ_W, 1'b0, 32'h400, 32'h0, 5'd11, 1'b1,
            1, 2, 1'b1, 4);
   endtask

   task automatic test_back_to_back;
      logic [31:0] r;
      i_ex_mem_op = OP_NONE;
      i_ex_mem_size = SZ_W;
      for (int i = 0; i < 6; i++) begin
         r = $urandom;
         i_ex_valid = 1'b1;
         i_ex_result = r;
         i_ex_rd = 5'(i + 1);
         i_ex_rd_we = 1'b1;
         tick;
         n_chk++;
         if ({o_wb_valid, o_wb_rd, o_wb_data, o_wb_exc} !==
             {1'b1, 5'(i + 1), r, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b %0d: got v=%b rd=%0d d=%h want v=1 rd=%0d d=%h",
                     i, o_wb_valid, o_wb_rd, o_wb_data, i + 1, r);
         end
      end
      i_ex_valid = 1'b0;
      tick;
      n_chk++;
      if (o_wb_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b drain: got v=%b want 0", o_wb_valid);
      end
   endtask

   task automatic test_reset_mid;
      i_ex_valid = 1'b1;
      i_ex_result = 32'h300;
      i_ex_rd = 5'd12;
      i_ex_rd_we = 1'b1;
      i_ex_mem_op = OP_LD;
      i_ex_mem_size = SZ_W;
      i_ex_mem_uns = 1'b0;
      tick;
      i_ex_valid = 1'b0;
      i_dmem_gnt = 1'b1;
      tick;
      i_dmem_gnt = 1'b0;
      i_rst = 1'b1;
      #2;
      n_chk++;
      if ({o_ex_ready, o_dmem_req, o_wb_valid, o_wb_exc, o_dmem_addr,
           o_dmem_be, o_wb_data, o_wb_rd} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid outputs: got rdy=%b req=%b v=%b a=%h d=%h want 0",
                  o_ex_ready, o_dmem_req, o_wb_valid, o_dmem_addr,
                  o_wb_data);
      end
      tick;
      i_rst = 1'b0;
      i_dmem_rvalid = 1'b1;
      i_dmem_rdata = 32'h5555_AAAA;
      tick;
      i_dmem_rvalid = 1'b0;
      n_chk++;
      if ({o_wb_valid, o_dmem_req, o_ex_ready} !== 3'b001) begin
         n_fail++;
         $display("FAIL rst_mid stray: got v=%b req=%b rdy=%b want 0 0 1",
                  o_wb_valid, o_dmem_req, o_ex_ready);
      end
      do_op("rst_mid_next", OP_LD, SZ_W, 1'b0, 32'h304, 32'h0, 5'd13,
            1'b1, 0, 0, 1'b0, 0);
   endtask

   task automatic test_random;
      logic [1:0] op, sz;
      logic [31:0] a;
      for (int i = 0; i < 60; i++) begin
         op = 2'($urandom_range(0, 2));
         sz = 2'($urandom_range(0, 2));
         a = (op == OP_NONE) ? $urandom :
             32'h1000 + 32'($urandom_range(0, 63));
         do_op($sformatf("rnd%0d", i), op, sz, 1'($urandom_range(0, 1)),
               a, $urandom, 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), $urandom_range(0, 2),
               $urandom_range(0, 2), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0);
      end
   endtask

   initial begin
      i_rst = 1'b1;
      i_ex_valid = 1'b0;
      i_ex_result = '0;
      i_ex_store_data = '0;
      i_ex_rd = '0;
      i_ex_rd_we = 1'b0;
      i_ex_mem_op = OP_NONE;
      i_ex_mem_size = SZ_B;
      i_ex_mem_uns = 1'b0;
      i_dmem_gnt = 1'b0;
      i_dmem_rvalid = 1'b0;
      i_dmem_rdata = '0;
      i_dmem_err = 1'b0;
      i_wb_ready = 1'b1;
      test_reset;
      test_alu;
      test_load_byte;
      test_store_half;
      test_misalign;
      test_access_fault;
      test_back_to_back;
      test_reset_mid;
      test_random;
      tick;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
